// File: rtl/serial_sum_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_sum_subtractor
// Brief    : Recovers operand a from a registered sum and known operand b
//            by bit-serial subtraction (diff = sum - b), LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sum_subtractor #(
  parameter int SUM_W = 8,
  parameter int OPD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic [OPD_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPD_W-1:0] a,
  output logic             neg,
  output logic             ovf
);

  localparam int CNT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   r_b;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  // Only the upper SUM_W-1 bits of the partial difference need storing;
  // the bit being produced this cycle completes the full word combinationally.
  logic [SUM_W-2:0]   r_diff;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OPD_W-1:0]   r_a;
  logic               r_neg;
  logic               r_ovf;

  logic               w_s;
  logic               w_t;
  logic               w_d;
  logic               w_borrow_nxt;
  logic [SUM_W-1:0]   w_diff_nxt;
  logic               w_last;
  logic               w_upper_nz;

  assign w_s          = r_sum[0];
  assign w_t          = r_b[0];
  assign w_d          = w_s ^ w_t ^ r_borrow;
  assign w_borrow_nxt = (~w_s & w_t) | (~(w_s ^ w_t) & r_borrow);
  assign w_diff_nxt   = {w_d, r_diff};
  assign w_last       = (r_cnt == c_LAST_CNT);
  assign w_upper_nz   = |w_diff_nxt[SUM_W-1:OPD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sum       <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sum      <= sum;
            r_b        <= {{(SUM_W-OPD_W){1'b0}}, b};
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum    <= {1'b0, r_sum[SUM_W-1:1]};
          r_b      <= {1'b0, r_b[SUM_W-1:1]};
          r_borrow <= w_borrow_nxt;
          r_diff   <= w_diff_nxt[SUM_W-1:1];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_a         <= w_diff_nxt[OPD_W-1:0];
            r_neg       <= w_borrow_nxt;
            r_ovf       <= w_borrow_nxt | w_upper_nz;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign a         = r_a;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_sum_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sum_subtractor
// Brief    : Directed and exhaustive scoreboard bench for serial_sum_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sum_subtractor;

  localparam int SUM_W = 8;
  localparam int OPD_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum;
  logic [OPD_W-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [OPD_W-1:0] a;
  logic             neg;
  logic             ovf;

  typedef struct packed {
    logic [OPD_W-1:0] a;
    logic             neg;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_sum_subtractor #(.SUM_W(SUM_W), .OPD_W(OPD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .neg       (neg),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 9-bit subtraction, borrow is the sign bit
  function automatic exp_t model(input logic [SUM_W-1:0] s, input logic [OPD_W-1:0] bb);
    logic [SUM_W:0] full;
    exp_t e;
    full  = {1'b0, s} - {{(SUM_W-OPD_W+1){1'b0}}, bb};
    e.a   = full[OPD_W-1:0];
    e.neg = full[SUM_W];
    e.ovf = full[SUM_W] | (full[SUM_W-1:OPD_W] != '0);
    return e;
  endfunction

  task automatic send(input logic [SUM_W-1:0] s, input logic [OPD_W-1:0] bb, input exp_t e);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    sum      = s;
    b        = bb;
    in_valid = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic collect(input string tag, input int stall, input bit toggle_iv);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, SUM_W);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = toggle_iv ? ~in_valid : 1'b0;
      tick();
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_a"}, {28'd0, a}, {28'd0, e.a});
    end
    in_valid = 1'b0;
    chk({tag, "_a"}, {28'd0, a}, {28'd0, e.a});
    chk({tag, "_neg"}, {31'd0, neg}, {31'd0, e.neg});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_rel_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    bit   seen;
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_neg", {31'd0, neg}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    e = '{a: 4'h7, neg: 1'b0, ovf: 1'b0};
    send(8'h0C, 4'h5, e);
    collect("t_0c_5", 0, 1'b0);

    e = '{a: 4'hE, neg: 1'b1, ovf: 1'b1};
    send(8'h03, 4'h5, e);
    collect("t_03_5", 0, 1'b0);

    e = '{a: 4'hF, neg: 1'b0, ovf: 1'b1};
    send(8'h1F, 4'h0, e);
    collect("t_1f_0", 0, 1'b0);

    send(8'h3C, 4'h3, model(8'h3C, 4'h3));
    collect("bp", 5, 1'b1);
    tick();
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Abort: reset lands on the edge that would process bit 4
    sum      = 8'h0C;
    b        = 4'h5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_a", {28'd0, a}, 32'd0);
    chk("abort_neg", {31'd0, neg}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        e = '{a: 4'(i), neg: 1'b0, ovf: 1'b0};
        send(8'(i + j), 4'(j), e);
        collect($sformatf("sweep_a%0d_b%0d", i, j), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
